// File: rtl/poly_requester.sv
// Request-side initiator for the polynomial evaluator: buffers operand sets,
// issues them one at a time, and returns tagged results downstream.
// Optional result checker is compiled in when POLY_REQ_CHECK_EN is defined.
module poly_requester #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_x,
    input  logic [15:0] req_a,
    input  logic [15:0] req_b,
    input  logic [15:0] req_c,
    output logic        ev_enable,
    input  logic        ev_ready,
    input  logic        ev_valid,
    input  logic [15:0] ev_result,
    output logic [7:0]  ev_x,
    output logic [15:0] ev_a,
    output logic [15:0] ev_b,
    output logic [15:0] ev_c,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_data,
    output logic [7:0]  res_seq,
    output logic        busy,
    output logic        error,
    output logic        mismatch,
    output logic [1:0]  dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high. A source holds valid and its payload until that edge; the sink
    // may raise or drop ready at will. req_* and res_* both follow this rule.

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [AW:0]   FULL_CNT  = (AW+1)'(DEPTH);
    localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    logic [1:0]    state;
    logic [TW-1:0] wait_cnt;
    logic          timeout_hit;

    logic [7:0]    mem_x   [DEPTH];
    logic [15:0]   mem_a   [DEPTH];
    logic [15:0]   mem_b   [DEPTH];
    logic [15:0]   mem_c   [DEPTH];
    logic [7:0]    mem_seq [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_next;
    logic [7:0]    seq_ctr;
    logic          push;
    logic          pop;

    logic [7:0]    head_x;
    logic [15:0]   head_a;
    logic [15:0]   head_b;
    logic [15:0]   head_c;
    logic [7:0]    head_seq;

    assign push        = req_valid & req_ready;
    assign timeout_hit = (wait_cnt == WAIT_LAST);
    // The head leaves the FIFO only once its request has finished, so an
    // in-flight request still occupies a slot.
    assign pop         = (state == S_WAIT) & (ev_valid | timeout_hit);

    assign head_x   = mem_x[rd_ptr];
    assign head_a   = mem_a[rd_ptr];
    assign head_b   = mem_b[rd_ptr];
    assign head_c   = mem_c[rd_ptr];
    assign head_seq = mem_seq[rd_ptr];

    assign busy      = (state != S_IDLE);
    assign dbg_state = state;

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + 1'b1;
        end else if (!push && pop) begin
            count_next = count - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem_x[wr_ptr]   <= req_x;
            mem_a[wr_ptr]   <= req_a;
            mem_b[wr_ptr]   <= req_b;
            mem_c[wr_ptr]   <= req_c;
            mem_seq[wr_ptr] <= seq_ctr;
        end
    end

    // req_ready is registered from the next occupancy so it reads 0 in reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            seq_ctr   <= 8'd0;
            req_ready <= 1'b0;
        end else begin
            count     <= count_next;
            req_ready <= (count_next != FULL_CNT);
            if (push) begin
                wr_ptr  <= wr_ptr + 1'b1;
                seq_ctr <= seq_ctr + 8'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            wait_cnt  <= '0;
            ev_enable <= 1'b0;
            ev_x      <= 8'd0;
            ev_a      <= 16'd0;
            ev_b      <= 16'd0;
            ev_c      <= 16'd0;
            res_valid <= 1'b0;
            res_data  <= 16'd0;
            res_seq   <= 8'd0;
            error     <= 1'b0;
        end else begin
            ev_enable <= 1'b0;
            case (state)
                S_IDLE: begin
                    if ((count != '0) && ev_ready) begin
                        state     <= S_ISSUE;
                        ev_enable <= 1'b1;
                        ev_x      <= head_x;
                        ev_a      <= head_a;
                        ev_b      <= head_b;
                        ev_c      <= head_c;
                    end
                end
                S_ISSUE: begin
                    state    <= S_WAIT;
                    wait_cnt <= '0;
                end
                S_WAIT: begin
                    // A result arriving on the timeout cycle is still taken.
                    if (ev_valid) begin
                        state     <= S_HOLD;
                        res_valid <= 1'b1;
                        res_data  <= ev_result;
                        res_seq   <= head_seq;
                    end else if (timeout_hit) begin
                        state <= S_IDLE;
                        error <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (res_ready) begin
                        state     <= S_IDLE;
                        res_valid <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef POLY_REQ_CHECK_EN
    logic [15:0] x16;
    logic [15:0] poly_val;
    logic [15:0] exp_val;

    // Low 16 bits of a product depend only on the low 16 bits of its factors,
    // so evaluating in 16-bit context equals the full-width result mod 2^16.
    assign x16      = {8'h00, ev_x};
    assign poly_val = ev_a * x16 * x16 + ev_b * x16 + ev_c;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            exp_val  <= 16'd0;
            mismatch <= 1'b0;
        end else begin
            if (state == S_ISSUE) begin
                exp_val <= poly_val;
            end
            if ((state == S_WAIT) && ev_valid && (ev_result != exp_val)) begin
                mismatch <= 1'b1;
            end
        end
    end
`else
    assign mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_poly_requester.sv
// Self-checking bench for poly_requester: evaluator responder, scoreboard of
// expected tagged results, directed corner cases plus randomized traffic.
module tb_poly_requester;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [7:0]  req_x = 8'd0;
  logic [15:0] req_a = 16'd0;
  logic [15:0] req_b = 16'd0;
  logic [15:0] req_c = 16'd0;
  logic        ev_enable;
  logic        ev_ready = 1'b0;
  logic        ev_valid = 1'b0;
  logic [15:0] ev_result = 16'd0;
  logic [7:0]  ev_x;
  logic [15:0] ev_a;
  logic [15:0] ev_b;
  logic [15:0] ev_c;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [15:0] res_data;
  logic [7:0]  res_seq;
  logic        busy;
  logic        error;
  logic        mismatch;
  logic [1:0]  dbg_state;

  poly_requester #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_a(req_a), .req_b(req_b), .req_c(req_c),
    .ev_enable(ev_enable), .ev_ready(ev_ready), .ev_valid(ev_valid), .ev_result(ev_result),
    .ev_x(ev_x), .ev_a(ev_a), .ev_b(ev_b), .ev_c(ev_c),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_seq(res_seq),
    .busy(busy), .error(error), .mismatch(mismatch), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clock = ~clock;

  int n_cmp  = 0;
  int n_fail = 0;

  // scoreboard: {seq, result} in issue order
  logic [23:0] exp_q[$];
  logic [7:0]  seq_model = 8'd0;
  bit          push_ok = 1'b0;
  bit          hold_prev = 1'b0;
  logic [23:0] hold_val = 24'd0;

  // evaluator responder state and knobs
  bit          ev_allow = 1'b1;
  bit          ev_hang = 1'b0;
  bit          ev_corrupt = 1'b0;
  bit          ev_pending = 1'b0;
  bit          prev_en = 1'b0;
  int          ev_lat = 0;
  int          en_count = 0;
  logic [55:0] ev_cap = 56'd0;

  function automatic logic [15:0] poly(input logic [7:0] x, input logic [15:0] a,
                                       input logic [15:0] b, input logic [15:0] c);
    logic [63:0] t;
    t = 64'(a) * 64'(x) * 64'(x) + 64'(b) * 64'(x) + 64'(c);
    return t[15:0];
  endfunction

  // One clock: observe handshakes at the falling edge, then update the
  // evaluator model just after the rising edge.
  task automatic tick();
    logic [23:0] exp_e;
    @(negedge clock);
    push_ok = 1'b0;
    if (hold_prev) begin
      n_cmp++;
      if (res_valid !== 1'b1 || {res_seq, res_data} !== hold_val) begin
        n_fail++;
        $display("FAIL hold_stable: got valid=%b seq/data=%h need 1 %h", res_valid, {res_seq, res_data}, hold_val);
      end
    end
    hold_prev = res_valid && !res_ready;
    hold_val  = {res_seq, res_data};
    if (req_valid && req_ready) begin
      exp_q.push_back({seq_model, poly(req_x, req_a, req_b, req_c)});
      seq_model++;
      push_ok = 1'b1;
    end
    if (res_valid && res_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL result_unexpected: got seq=%0d data=%h need no result", res_seq, res_data);
      end else begin
        exp_e = exp_q.pop_front();
        if ({res_seq, res_data} !== exp_e) begin
          n_fail++;
          $display("FAIL result: got seq=%0d data=%h need seq=%0d data=%h", res_seq, res_data, exp_e[23:16], exp_e[15:0]);
        end
      end
    end
    @(posedge clock);
    #1;
    ev_valid = 1'b0;
    if (ev_enable) begin
      n_cmp++;
      if (prev_en) begin
        n_fail++;
        $display("FAIL enable_width: got ev_enable high on consecutive cycles need single pulse");
      end
      en_count++;
      ev_cap = {ev_x, ev_a, ev_b, ev_c};
      if (!ev_hang) begin
        ev_pending = 1'b1;
        ev_lat = $urandom_range(1, 4);
      end
    end else if (ev_pending) begin
      n_cmp++;
      if ({ev_x, ev_a, ev_b, ev_c} !== ev_cap) begin
        n_fail++;
        $display("FAIL operands_held: got %h need %h", {ev_x, ev_a, ev_b, ev_c}, ev_cap);
      end
      ev_lat--;
      if (ev_lat == 0) begin
        ev_valid = 1'b1;
        ev_result = ev_corrupt ? 16'h0000 : poly(ev_cap[55:48], ev_cap[47:32], ev_cap[31:16], ev_cap[15:0]);
        ev_pending = 1'b0;
      end
    end
    prev_en = ev_enable;
    ev_ready = ev_allow && !ev_pending;
  endtask

  // driver tasks
  task automatic push(input logic [7:0] x, input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    int guard = 0;
    req_valid = 1'b1;
    req_x = x; req_a = a; req_b = b; req_c = c;
    do begin
      tick();
      guard++;
    end while (!push_ok && guard < 200);
    req_valid = 1'b0;
    n_cmp++;
    if (!push_ok) begin
      n_fail++;
      $display("FAIL push_timeout: got no acceptance in %0d cycles need acceptance", guard);
    end
  endtask

  task automatic drain();
    int guard = 0;
    res_ready = 1'b1;
    while ((exp_q.size() != 0 || busy) && guard < 2000) begin
      tick();
      guard++;
    end
    n_cmp++;
    if (guard >= 2000) begin
      n_fail++;
      $display("FAIL drain: got %0d results outstanding busy=%b need 0 and idle", exp_q.size(), busy);
    end
  endtask

  task automatic wait_enable();
    int guard = 0;
    while (ev_enable !== 1'b1 && guard < 50) begin
      tick();
      guard++;
    end
    n_cmp++;
    if (ev_enable !== 1'b1) begin
      n_fail++;
      $display("FAIL wait_enable: got ev_enable=%b need 1 within 50 cycles", ev_enable);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    ev_allow = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    n_cmp++;
    if ({req_ready, busy, ev_enable, res_valid, error, mismatch} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b need 000000", {req_ready, busy, ev_enable, res_valid, error, mismatch});
    end
    n_cmp++;
    if ({ev_x, ev_a, ev_b, ev_c, res_data, res_seq} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got %h need 0", {ev_x, ev_a, ev_b, ev_c, res_data, res_seq});
    end
    reset = 1'b1;
    tick();
    n_cmp++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: got req_ready=%b busy=%b need 1 0", req_ready, busy);
    end
  endtask

  task automatic test_directed();
    ev_allow = 1'b1;
    res_ready = 1'b1;
    push(8'd2, 16'd3, 16'd4, 16'd5);
    n_cmp++;
    if (ev_enable !== 1'b0) begin
      n_fail++;
      $display("FAIL latency_early: got ev_enable=%b one cycle after push need 0", ev_enable);
    end
    tick();
    n_cmp++;
    if (ev_enable !== 1'b1) begin
      n_fail++;
      $display("FAIL latency: got ev_enable=%b two cycles after push need 1", ev_enable);
    end
    drain();
    n_cmp++;
    if (res_data !== 16'd25 || res_seq !== 8'd0) begin
      n_fail++;
      $display("FAIL case1: got data=%0d seq=%0d need 25 0", res_data, res_seq);
    end
    push(8'd0, 16'd7, 16'd9, 16'h1234);
    drain();
    n_cmp++;
    if (res_data !== 16'h1234) begin
      n_fail++;
      $display("FAIL case2a: got data=%h need 1234", res_data);
    end
    push(8'd255, 16'd1, 16'd0, 16'd0);
    drain();
    n_cmp++;
    if (res_data !== 16'hFE01 || res_seq !== 8'd2) begin
      n_fail++;
      $display("FAIL case2b: got data=%h seq=%0d need fe01 2", res_data, res_seq);
    end
  endtask

  task automatic test_back_to_back();
    int accepted = 0;
    ev_allow = 1'b0;
    res_ready = 1'b1;
    tick();
    req_valid = 1'b1;
    req_x = 8'($urandom); req_a = 16'($urandom); req_b = 16'($urandom); req_c = 16'($urandom);
    for (int i = 0; i < 7; i++) begin
      tick();
      if (push_ok) begin
        accepted++;
        req_x = 8'($urandom); req_a = 16'($urandom); req_b = 16'($urandom); req_c = 16'($urandom);
      end
      if (i == 3) begin
        n_cmp++;
        if (accepted != 4 || req_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL fifo_full: got accepted=%0d req_ready=%b need 4 0", accepted, req_ready);
        end
      end
    end
    req_valid = 1'b0;
    n_cmp++;
    if (accepted != DEPTH) begin
      n_fail++;
      $display("FAIL fifo_overflow: got accepted=%0d need %0d", accepted, DEPTH);
    end
    ev_allow = 1'b1;
    drain();
  endtask

  task automatic test_random();
    int sent = 0;
    int guard = 0;
    while ((sent < 60 || req_valid) && guard < 5000) begin
      if (!req_valid && sent < 60 && $urandom_range(0, 2) != 0) begin
        req_valid = 1'b1;
        req_x = 8'($urandom); req_a = 16'($urandom); req_b = 16'($urandom); req_c = 16'($urandom);
      end
      res_ready = ($urandom_range(0, 3) != 0);
      ev_allow = ($urandom_range(0, 4) != 0);
      tick();
      guard++;
      if (push_ok) begin
        req_valid = 1'b0;
        sent++;
      end
    end
    req_valid = 1'b0;
    ev_allow = 1'b1;
    n_cmp++;
    if (guard >= 5000) begin
      n_fail++;
      $display("FAIL random_stall: got %0d sent need 60 within budget", sent);
    end
    drain();
  endtask

  task automatic test_timeout();
    logic [23:0] dropped;
    ev_allow = 1'b1;
    ev_hang = 1'b1;
    res_ready = 1'b1;
    push(8'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
    wait_enable();
    repeat (TIMEOUT) tick();
    n_cmp++;
    if (error !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_early: got error=%b after %0d wait cycles need 0", error, TIMEOUT - 1);
    end
    tick();
    n_cmp++;
    if (error !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout: got error=%b busy=%b need 1 0", error, busy);
    end
    if (exp_q.size() > 0) dropped = exp_q.pop_front();
    ev_hang = 1'b0;
    push(8'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
    drain();
    n_cmp++;
    if (error !== 1'b1) begin
      n_fail++;
      $display("FAIL error_sticky: got error=%b need 1", error);
    end
  endtask

  task automatic test_stall();
    int base;
    int guard = 0;
    ev_allow = 1'b1;
    res_ready = 1'b0;
    push(8'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
    while (res_valid !== 1'b1 && guard < 50) begin
      tick();
      guard++;
    end
    push(8'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
    base = en_count;
    repeat (20) tick();
    n_cmp++;
    if (en_count != base || res_valid !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL stall: got enables=%0d valid=%b busy=%b need 0 1 1", en_count - base, res_valid, busy);
    end
    res_ready = 1'b1;
    tick();
    n_cmp++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_release: got valid=%b busy=%b need 0 0", res_valid, busy);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    int base;
    ev_allow = 1'b1;
    ev_hang = 1'b1;
    res_ready = 1'b1;
    push(8'($urandom) | 8'd1, 16'($urandom) | 16'd1, 16'($urandom), 16'($urandom));
    push(8'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
    wait_enable();
    tick();
    tick();
    n_cmp++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_busy: got busy=%b need 1", busy);
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({req_ready, busy, ev_enable, res_valid, error, mismatch, ev_x, ev_a, ev_b, ev_c, res_data, res_seq} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: got flags=%b ev_x=%h res=%h need all 0",
               {req_ready, busy, ev_enable, res_valid, error, mismatch}, ev_x, res_data);
    end
    exp_q.delete();
    seq_model = 8'd0;
    hold_prev = 1'b0;
    ev_pending = 1'b0;
    ev_hang = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    n_cmp++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_release: got req_ready=%b busy=%b need 1 0", req_ready, busy);
    end
    base = en_count;
    repeat (5) tick();
    n_cmp++;
    if (busy !== 1'b0 || en_count != base) begin
      n_fail++;
      $display("FAIL fifo_flushed: got busy=%b enables=%0d need 0 0", busy, en_count - base);
    end
    push(8'd2, 16'd3, 16'd4, 16'd5);
    drain();
    n_cmp++;
    if (res_data !== 16'd25 || res_seq !== 8'd0) begin
      n_fail++;
      $display("FAIL post_reset: got data=%0d seq=%0d need 25 0", res_data, res_seq);
    end
  endtask

  task automatic test_check();
`ifdef POLY_REQ_CHECK_EN
    logic [23:0] e;
    n_cmp++;
    if (mismatch !== 1'b0) begin
      n_fail++;
      $display("FAIL mismatch_early: got %b need 0", mismatch);
    end
    ev_corrupt = 1'b1;
    push(8'd2, 16'd3, 16'd4, 16'd5);
    e = exp_q.pop_back();
    exp_q.push_back({e[23:16], 16'h0000});
    drain();
    ev_corrupt = 1'b0;
    n_cmp++;
    if (mismatch !== 1'b1) begin
      n_fail++;
      $display("FAIL mismatch: got %b need 1", mismatch);
    end
`else
    n_cmp++;
    if (mismatch !== 1'b0) begin
      n_fail++;
      $display("FAIL mismatch_tied: got %b need 0", mismatch);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_timeout();
    test_stall();
    test_reset_mid();
    test_check();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
